ctrl_mod_fac_seq: RTL and testbench

CTRL_MOD_FAC_SEQ -- requirements
Module: ctrl_mod_fac_seq

---
 rtl/ctrl_mod_fac_seq.sv | 135 +++++++++++++
 tb/tb_ctrl_mod_fac_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mod_fac_seq.sv
// ctrl_mod_fac_seq
// Sequences multiplier-value groups for a factor multiplier. Each en strobe
// from the upstream stage launches one group: the block pulses en_fac (and
// the identical alert_mod handshake) and presents the registered group index
// on mul_val_sel. After group N_GRP-1 the index wraps and frame_done pulses.
// A frame left idle for too long, or cut short by clr, is dropped; abort
// pulses only when a partial frame (index not 0) is thrown away.
//
// Parameters:
//   N_GRP   - groups per frame (2..16)
//   TIMEOUT - en-free idle count in RUN that abandons the frame (1..255)
//
// Ports:
//   clk         - clock, rising edge
//   rstn        - asynchronous active-low reset
//   en          - one-cycle group-start strobe
//   clr         - synchronous abort, has priority over en
//   en_fac      - registered enable pulse to the factor multiplier
//   mul_val_sel - registered group index (always < N_GRP)
//   alert_mod   - registered handshake pulse, identical to en_fac
//   frame_done  - registered pulse when group N_GRP-1 completes
//   abort       - registered pulse when a partial frame is dropped
//   busy        - high while the registered state is RUN

module ctrl_mod_fac_seq #(
  parameter int N_GRP   = 2,
  parameter int TIMEOUT = 3,
  localparam int SEL_W  = (N_GRP > 2) ? $clog2(N_GRP) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  output logic             en_fac,
  output logic [SEL_W-1:0] mul_val_sel,
  output logic             alert_mod,
  output logic             frame_done,
  output logic             abort,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_GRP - 1);
  localparam logic [7:0]       TO_CNT   = 8'(TIMEOUT);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic [7:0]       idle_cnt, idle_cnt_n;
  logic             pulse_n;
  logic             done_n;
  logic             abort_n;

  // State and all outputs are registered; busy is a direct decode of the
  // state register, so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      mul_val_sel <= '0;
      idle_cnt    <= '0;
      en_fac      <= 1'b0;
      alert_mod   <= 1'b0;
      frame_done  <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= state_n;
      mul_val_sel <= sel_n;
      idle_cnt    <= idle_cnt_n;
      en_fac      <= pulse_n;
      alert_mod   <= pulse_n;
      frame_done  <= done_n;
      abort       <= abort_n;
    end
  end

  assign busy = (state == RUN);

  always_comb begin
    state_n    = state;
    sel_n      = mul_val_sel;
    idle_cnt_n = idle_cnt;
    pulse_n    = 1'b0;
    done_n     = 1'b0;
    abort_n    = 1'b0;

    if (clr) begin
      // clr overrides en in every state; only a partial frame in RUN aborts.
      state_n    = IDLE;
      sel_n      = '0;
      idle_cnt_n = '0;
      abort_n    = (state == RUN) && (mul_val_sel != '0);
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state_n    = RUN;
            sel_n      = '0;
            idle_cnt_n = '0;
            pulse_n    = 1'b1;
          end
        end

        RUN: begin
          if (en) begin
            // en beats a timeout that would fire in the same cycle.
            pulse_n    = 1'b1;
            idle_cnt_n = '0;
            if (mul_val_sel == LAST_SEL) begin
              sel_n  = '0;
              done_n = 1'b1;
            end else begin
              sel_n = mul_val_sel + 1'b1;
            end
          end else if (idle_cnt == TO_CNT) begin
            state_n    = IDLE;
            sel_n      = '0;
            idle_cnt_n = '0;
            abort_n    = (mul_val_sel != '0);
          end else if (idle_cnt != '1) begin
            idle_cnt_n = idle_cnt + 8'd1;
          end
        end

        default: begin
          state_n = IDLE;
          sel_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_mod_fac_seq.sv
// Bench for ctrl_mod_fac_seq. Three instances:
//   d0: N_GRP=4, TIMEOUT=3  (main table, clr, timeout, reset)
//   d1: defaults N_GRP=2, TIMEOUT=3
//   d2: N_GRP=3, TIMEOUT=1  (non-power-of-2 wrap)
// Inputs change 1 ns after a rising edge; outputs are checked there too.

module tb_ctrl_mod_fac_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] en_v;
  logic [2:0] clr_v;

  logic [1:0] sel0;
  logic [0:0] sel1;
  logic [1:0] sel2;
  logic [2:0] ef, al, fd, ab, bu;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ctrl_mod_fac_seq #(.N_GRP(4), .TIMEOUT(3)) d0 (
    .clk(clk), .rstn(rstn), .en(en_v[0]), .clr(clr_v[0]),
    .en_fac(ef[0]), .mul_val_sel(sel0), .alert_mod(al[0]),
    .frame_done(fd[0]), .abort(ab[0]), .busy(bu[0])
  );

  ctrl_mod_fac_seq d1 (
    .clk(clk), .rstn(rstn), .en(en_v[1]), .clr(clr_v[1]),
    .en_fac(ef[1]), .mul_val_sel(sel1), .alert_mod(al[1]),
    .frame_done(fd[1]), .abort(ab[1]), .busy(bu[1])
  );

  ctrl_mod_fac_seq #(.N_GRP(3), .TIMEOUT(1)) d2 (
    .clk(clk), .rstn(rstn), .en(en_v[2]), .clr(clr_v[2]),
    .en_fac(ef[2]), .mul_val_sel(sel2), .alert_mod(al[2]),
    .frame_done(fd[2]), .abort(ab[2]), .busy(bu[2])
  );

  typedef struct {
    int         d;
    bit         en;
    bit         clr;
    logic [3:0] sel;
    bit         al;
    bit         fd;
    bit         ab;
    bit         bu;
  } vec_t;

  vec_t vq[$];

  // Packed view {sel, en_fac, alert_mod, frame_done, abort, busy}.
  function automatic logic [8:0] observe(input int d);
    logic [3:0] s;
    case (d)
      0:       s = {2'b00, sel0};
      1:       s = {3'b000, sel1};
      default: s = {2'b00, sel2};
    endcase
    return {s, ef[d], al[d], fd[d], ab[d], bu[d]};
  endfunction

  task automatic check(input string name, input int d, input logic [8:0] exp);
    logic [8:0] act;
    act = observe(d);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d: got sel=%0d ef=%b al=%b fd=%b ab=%b busy=%b, want sel=%0d ef=%b al=%b fd=%b ab=%b busy=%b",
               name, d, act[8:5], act[4], act[3], act[2], act[1], act[0],
               exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input int d, input bit e, input bit c, input int s,
                     input bit a, input bit f, input bit b, input bit y);
    vec_t v;
    v.d = d; v.en = e; v.clr = c; v.sel = 4'(s);
    v.al = a; v.fd = f; v.ab = b; v.bu = y;
    vq.push_back(v);
  endtask

  task automatic step(input int d, input bit e, input bit c);
    en_v  = '0;
    clr_v = '0;
    en_v[d]  = e;
    clr_v[d] = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn  = 1'b0;
    en_v  = '0;
    clr_v = '0;

    //   d  en clr sel al fd ab busy
    // d0: idle, then 9 back-to-back en (two wraps)
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 2, 1, 0, 0, 1);
    add(0, 1, 0, 3, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 2, 1, 0, 0, 1);
    add(0, 1, 0, 3, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 1);
    // timeout after completed frame: no abort
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // partial frame timeout: abort 4 cycles after last en
    add(0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // en exactly on the timeout cycle wins
    add(0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 2, 1, 0, 0, 1);
    // clr with en at sel=2
    add(0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // clr in IDLE, and clr in RUN at sel=0: no abort
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // d1 defaults: en at cycles 0,2,4 then silence
    add(1, 1, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    // d2 N_GRP=3: wraps 2->0, short timeout aborts at sel=1
    add(2, 1, 0, 0, 1, 0, 0, 1);
    add(2, 1, 0, 1, 1, 0, 0, 1);
    add(2, 1, 0, 2, 1, 0, 0, 1);
    add(2, 1, 0, 0, 1, 1, 0, 1);
    add(2, 1, 0, 1, 1, 0, 0, 1);
    add(2, 0, 0, 1, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0, 1, 0);

    #2;
    for (int d = 0; d < 3; d++) check("reset_state", d, 9'h000);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].d, vq[i].en, vq[i].clr);
      check($sformatf("vec%0d", i), vq[i].d,
            {vq[i].sel, vq[i].al, vq[i].al, vq[i].fd, vq[i].ab, vq[i].bu});
    end

    // Asynchronous reset mid-frame on d0 at sel=1.
    step(0, 1, 0);
    check("rst_pre_a", 0, {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    step(0, 1, 0);
    check("rst_pre_b", 0, {4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    en_v = '0;
    #3;
    rstn = 1'b0;
    #1;
    check("rst_async", 0, 9'h000);
    @(posedge clk);
    #1;
    check("rst_held", 0, 9'h000);
    @(negedge clk);
    rstn = 1'b1;
    step(0, 0, 0);
    check("rst_no_abort", 0, 9'h000);
    step(0, 1, 0);
    check("rst_restart", 0, {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    step(0, 0, 0);
    check("rst_pulse_end", 0, {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
